banco_registradores_param: RTL
==============================

# banco_registradores_param

Parametrised general-purpose register file for the datapath, successor to the fixed 32x32 bank. It provides two combinational read ports and two write ports, an optional hardwired zero register, and an optional write-to-read bypass. It also keeps a per-register pending-write scoreboard, so decode can detect RAW hazards against in-flight producers. It sits between decode (reads, reservations) and writeback (writes, releases).

## Interface
- LARGURA, 32, data width in bits
- NUM_REGS, 32, number of registers (power of two, ≥2)
- END, $clog2(NUM_REGS), register address width
- ZERO_FIXO, 1, 1 = register 0 reads 0, ignores writes and is never pending
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports
- clock  input  1  single clock; all state updates on posedge
- reset  input  1  synchronous, active-high; sampled on posedge clock
- R1, R2  input  END  read addresses
- leituraR1, leituraR2  output  LARGURA  read data (combinational)
- pendenteR1, pendenteR2  output  1  addressed register has a pending write (combinational)
- regWrite  input  1  write enable, port A
- RD  input  END  write address, port A
- dadosEscrita  input  LARGURA  write data, port A
- regWriteB  input  1  write enable, port B
- RDB  input  END  write address, port B
- dadosEscritaB  input  LARGURA  write data, port B
- reserva  input  1  mark RDReserva pending
- RDReserva  input  END  register being reserved
- numPendentes  output  END+1  registered count of pending registers

## Operation
- Storage: NUM_REGS x LARGURA regs array; pend[NUM_REGS] bit vector.
- Reset (reset=1 at posedge): all registers, all pend bits and numPendentes go to 0. Writes and reservations in that cycle are ignored. Reset has priority over everything.
- Write: at posedge, if regWrite then regs[RD] <= dadosEscrita; if regWriteB then regs[RDB] <= dadosEscritaB.
- Write collision: both ports enabled with RD == RDB means port B data is stored.
- ZERO_FIXO=1: writes and reservations addressed to 0 are dropped. leituraR1/R2 are 0 for address 0, and pendenteR1/R2 are 0 for address 0.
- Read, BYPASS=0: leitura = regs[addr].
- Read, BYPASS=1: the value is taken by priority: port B write data if regWriteB and RDB == addr; else port A write data if regWrite and RD == addr; else regs[addr]. The zero rule overrides the bypass.
- Scoreboard: a write on either port clears pend[RD]/pend[RDB] at posedge. reserva sets pend[RDReserva] at posedge.
- Scoreboard collision: reserve and release of the same register in the same cycle leaves the bit set (the new producer wins).
- Re-reserving an already-pending register leaves it set; the count does not change.
- Releasing a non-pending register is a no-op.
- pendenteRx, BYPASS=0: pendenteRx = pend[Rx].
- pendenteRx, BYPASS=1: pendenteRx = pend[Rx] & ~(register written this cycle).
- numPendentes: registered population count of pend after the update. It equals popcount(pend) at all times after a clock edge.

## Timing
- Read latency: 0 cycles (combinational from R1/R2 and the write ports).
- Write visible through storage: from the cycle after the posedge. With BYPASS=1 it is also visible in the same cycle.
- Reservation visible on pendenteRx: the cycle after the reserva posedge.
- numPendentes update: 1 cycle.
- Outputs after reset: leitura = 0 for every address, pendente = 0, numPendentes = 0.
- Reset asserted mid-operation: it discards in-flight writes and reservations in the same cycle; there is no partial update.

## Test plan
- Reset then read all: reset=1 for 1 cycle, then sweep R1/R2 over 0..31 -> all leitura = 0, all pendente = 0, numPendentes = 0.
- Write then read, BYPASS=0: write 0xDEADBEEF to r5 -> leituraR1 for R1=5 is old value 0 during the write cycle and 0xDEADBEEF from the next cycle.
- Bypass and collision, BYPASS=1: port A writes 0x11111111 and port B writes 0x22222222, both to r7, same cycle, R1=7 -> leituraR1 = 0x22222222 in that cycle, and r7 holds 0x22222222 afterwards.
- Zero register: write 0xFFFFFFFF to r0 with reserva on r0 -> leituraR1 for R1=0 stays 0, pendenteR1 = 0, numPendentes = 0.
- Scoreboard: reserve r3, then r9 -> numPendentes goes 1, 2.
  - Same cycle, release r3 while reserving r3 -> pend[3] stays 1, numPendentes = 2.
  - Release r3 and r9 -> numPendentes = 0.
- Reset mid-operation: with 4 registers pending, assert reset together with a write of 0x5 to r4 -> numPendentes = 0 and r4 = 0 on the next cycle.

Source files
------------

// File: rtl/banco_registradores_param.sv
// Parametrised register file: 2 combinational read ports, 2 write ports, RAW scoreboard.
// Latency: reads 0 cycles (optional same-cycle bypass), writes/reservations visible next cycle.
// Backpressure: none; every write, release and reservation is accepted in the cycle it arrives.
module banco_registradores_param #(
  parameter int LARGURA   = 32,
  parameter int NUM_REGS  = 32,
  parameter int END       = $clog2(NUM_REGS),
  parameter bit ZERO_FIXO = 1'b1,
  parameter bit BYPASS    = 1'b1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [END-1:0]     R1,
  input  logic [END-1:0]     R2,
  output logic [LARGURA-1:0] leituraR1,
  output logic [LARGURA-1:0] leituraR2,
  output logic               pendenteR1,
  output logic               pendenteR2,
  input  logic               regWrite,
  input  logic [END-1:0]     RD,
  input  logic [LARGURA-1:0] dadosEscrita,
  input  logic               regWriteB,
  input  logic [END-1:0]     RDB,
  input  logic [LARGURA-1:0] dadosEscritaB,
  input  logic               reserva,
  input  logic [END-1:0]     RDReserva,
  output logic [END:0]       numPendentes
);

  logic [LARGURA-1:0] regs_q [NUM_REGS];
  logic [LARGURA-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] pend_q, pend_d;
  logic [END:0]        num_pend_q, num_pend_d;

  logic we_a, we_b, res_en;

  // Qualified enables: anything aimed at the hardwired zero register is dropped.
  always_comb begin
    we_a   = regWrite  && !(ZERO_FIXO && (RD == '0));
    we_b   = regWriteB && !(ZERO_FIXO && (RDB == '0));
    res_en = reserva   && !(ZERO_FIXO && (RDReserva == '0));
  end

  // Next storage contents; port B is applied last so it wins an address collision.
  always_comb begin
    regs_d = regs_q;
    if (we_a) regs_d[RD]  = dadosEscrita;
    if (we_b) regs_d[RDB] = dadosEscritaB;
  end

  // Next scoreboard: writes release, then a reservation sets, so a new producer wins.
  always_comb begin
    pend_d = pend_q;
    if (we_a)   pend_d[RD]        = 1'b0;
    if (we_b)   pend_d[RDB]       = 1'b0;
    if (res_en) pend_d[RDReserva] = 1'b1;
    num_pend_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      num_pend_d = num_pend_d + (END+1)'(pend_d[i]);
    end
  end

  // State update; reset discards everything presented in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      pend_q     <= '0;
      num_pend_q <= '0;
    end else begin
      regs_q     <= regs_d;
      pend_q     <= pend_d;
      num_pend_q <= num_pend_d;
    end
  end

  // Read port 1: storage, optionally overridden by in-flight write data (B over A), zero rule last.
  always_comb begin
    leituraR1  = regs_q[R1];
    pendenteR1 = pend_q[R1];
    if (BYPASS) begin
      if (we_b && (RDB == R1)) begin
        leituraR1 = dadosEscritaB;
      end else if (we_a && (RD == R1)) begin
        leituraR1 = dadosEscrita;
      end
      if ((we_a && (RD == R1)) || (we_b && (RDB == R1))) begin
        pendenteR1 = 1'b0;
      end
    end
    if (ZERO_FIXO && (R1 == '0)) begin
      leituraR1  = '0;
      pendenteR1 = 1'b0;
    end
  end

  // Read port 2: same rules as port 1.
  always_comb begin
    leituraR2  = regs_q[R2];
    pendenteR2 = pend_q[R2];
    if (BYPASS) begin
      if (we_b && (RDB == R2)) begin
        leituraR2 = dadosEscritaB;
      end else if (we_a && (RD == R2)) begin
        leituraR2 = dadosEscrita;
      end
      if ((we_a && (RD == R2)) || (we_b && (RDB == R2))) begin
        pendenteR2 = 1'b0;
      end
    end
    if (ZERO_FIXO && (R2 == '0)) begin
      leituraR2  = '0;
      pendenteR2 = 1'b0;
    end
  end

  assign numPendentes = num_pend_q;

endmodule
